// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_type;

    localparam int unsigned WAIT_CNT_W = 4;

    // Unsigned window check done in 33 bits so the upper bound cannot wrap.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input int unsigned depth_log2);
        logic [32:0] lo;
        logic [32:0] hi;
        lo = {1'b0, base};
        hi = lo + (33'd4 << depth_log2);
        return ({1'b0, addr} >= lo) && ({1'b0, addr} < hi);
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-wide RAM with per-byte write enables and a registered read port.
module dmem_ram #(
    parameter int unsigned DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [3:0]            we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
            if (we == 4'h0) rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one-cycle requests, waits WAIT_CYCLES,
// then performs one RAM access and returns a single-cycle mem_ready.
//
// state | meaning
// IDLE  | no request in flight
// WAIT  | request latched, counting down before the access
// RESP  | access done, mem_ready high; may accept the next request
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2  = 12,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        mem_error,
    output logic        overrun
);

    localparam logic                  DIRECT    = (WAIT_CYCLES == 0);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = DIRECT ? '0 : WAIT_CNT_W'(WAIT_CYCLES - 1);

    dmem_state_type        state, state_nxt;
    logic [WAIT_CNT_W-1:0] cnt, cnt_nxt;
    logic                  accept;

    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;

    logic [31:0] acc_addr, acc_wdata, acc_off;
    logic [3:0]  acc_wstrb;
    logic        acc_in_range, enter_resp, ram_en;
    logic        resp_err, resp_rd, overrun_q;
    logic [31:0] ram_rdata;
    logic        unused_bits;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        case (state)
            IDLE, RESP: begin
                state_nxt = IDLE;
                if (mem_valid) begin
                    accept = 1'b1;
                    if (DIRECT) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) state_nxt = RESP;
                else           cnt_nxt   = cnt - 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // With no wait states the access uses the request on the bus this cycle.
    always_comb begin
        acc_addr  = mem_addr;
        acc_wdata = mem_wdata;
        acc_wstrb = mem_wstrb;
        if (state == WAIT) begin
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_wstrb = req_wstrb;
        end
    end

    assign acc_off      = acc_addr - BASE_ADDR;
    assign acc_in_range = addr_in_range(acc_addr, BASE_ADDR, DEPTH_LOG2);
    assign enter_resp   = rst && (state_nxt == RESP);
    assign ram_en       = enter_resp && acc_in_range;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            overrun_q <= 1'b0;
            resp_err  <= 1'b0;
            resp_rd   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (mem_valid && state == WAIT) overrun_q <= 1'b1;
            if (enter_resp) begin
                resp_err <= !acc_in_range;
                resp_rd  <= acc_in_range && (acc_wstrb == 4'h0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && accept) begin
            req_addr  <= mem_addr;
            req_wdata <= mem_wdata;
            req_wstrb <= mem_wstrb;
        end
    end

    dmem_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (acc_wstrb),
        .addr  (acc_off[DEPTH_LOG2+1:2]),
        .wdata (acc_wdata),
        .rdata (ram_rdata)
    );

    assign mem_ready = (state == RESP);
    assign mem_error = mem_ready && resp_err;
    assign mem_rdata = (mem_ready && resp_rd) ? ram_rdata : 32'h0;
    assign overrun   = overrun_q;

    assign unused_bits = ^{mem_instr, acc_off[31:DEPTH_LOG2+2], acc_off[1:0]};

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances with different wait
// counts, directed scenarios plus random traffic against a word-array model.
module tb_dmem_responder;

    localparam int          NI    = 3;
    localparam int          D     = 6;
    localparam int          WORDS = 64;
    localparam int          WC   [NI] = '{1, 0, 3};
    localparam logic [31:0] BASE [NI] = '{32'h0, 32'h0, 32'h1000};
    localparam longint      INF   = 64'h7fff_ffff_ffff_ffff;

    typedef struct {
        longint      due;
        logic [31:0] rdata;
        logic [31:0] mask;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tie_zero = 1'b0;
    logic        mem_valid [NI];
    logic [31:0] mem_addr  [NI];
    logic [31:0] mem_wdata [NI];
    logic [3:0]  mem_wstrb [NI];
    logic        mem_ready [NI];
    logic [31:0] mem_rdata [NI];
    logic        mem_error [NI];
    logic        overrun   [NI];

    exp_t        sb [NI][$];
    logic [31:0] mdat   [NI][WORDS];
    logic [3:0]  mknown [NI][WORDS];
    longint      next_free [NI];
    longint      ovr_from  [NI];
    longint      cyc = 0;
    logic        rst_at_edge = 1'b0;
    int          n_tests = 0;
    int          n_fail  = 0;
    exp_t        mon_e;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dmem_responder #(
            .DEPTH_LOG2  (D),
            .BASE_ADDR   (BASE[g]),
            .WAIT_CYCLES (WC[g])
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .mem_valid (mem_valid[g]),
            .mem_instr (tie_zero),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_wstrb (mem_wstrb[g]),
            .mem_ready (mem_ready[g]),
            .mem_rdata (mem_rdata[g]),
            .mem_error (mem_error[g]),
            .overrun   (overrun[g])
        );
    end

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst;
    end

    function automatic logic [31:0] lane_mask(input logic [3:0] s);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{s[b]}};
        return m;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        mem_valid[i] = 1'b1;
        mem_addr[i]  = a;
        mem_wdata[i] = d;
        mem_wstrb[i] = s;
        step();
        mem_valid[i] = 1'b0;
    endtask

    // Reference: serial request handling, busy for WC+1 cycles after acceptance.
    task automatic issue(input int i, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        exp_t   e;
        longint la, lb;
        int     idx;
        if (cyc >= next_free[i]) begin
            next_free[i] = cyc + WC[i] + 1;
            la      = longint'(a);
            lb      = longint'(BASE[i]);
            e.due   = cyc + WC[i] + 1;
            e.rdata = 32'h0;
            e.mask  = 32'hffff_ffff;
            e.err   = 1'b0;
            if (la >= lb && la < lb + 4 * WORDS) begin
                idx = int'((la - lb) / 4);
                if (s == 4'h0) begin
                    e.rdata = mdat[i][idx];
                    e.mask  = lane_mask(mknown[i][idx]);
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (s[b]) mdat[i][idx][8*b +: 8] = d[8*b +: 8];
                    mknown[i][idx] = mknown[i][idx] | s;
                end
            end else begin
                e.err = 1'b1;
            end
            sb[i].push_back(e);
        end else if (ovr_from[i] == INF) begin
            ovr_from[i] = cyc + 1;
        end
        drive(i, a, d, s);
    endtask

    task automatic drain(input int i);
        int n = 0;
        while (sb[i].size() > 0 && n < 60) begin
            step();
            n++;
        end
        n_tests++;
        if (sb[i].size() > 0) begin
            n_fail++;
            $display("FAIL drain_timeout inst%0d: %0d responses still pending, want 0", i, sb[i].size());
            sb[i].delete();
        end
        step();
    endtask

    task automatic do_reset(input int n, input bit with_valid);
        rst = 1'b0;
        if (with_valid) begin
            for (int i = 0; i < NI; i++) begin
                mem_valid[i] = 1'b1;
                mem_addr[i]  = BASE[i] + 32'h10;
                mem_wdata[i] = 32'h1111_1111;
                mem_wstrb[i] = 4'hF;
            end
        end
        repeat (n) step();
        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            mem_valid[i] = 1'b0;
            next_free[i] = 0;
        end
    endtask

    always @(negedge clk) begin
        if (cyc > 0) begin
            for (int i = 0; i < NI; i++) begin
                if (!rst_at_edge) begin
                    n_tests++;
                    if (mem_ready[i] || mem_rdata[i] != 32'h0 || mem_error[i] || overrun[i]) begin
                        n_fail++;
                        $display("FAIL reset_outputs inst%0d: ready=%b rdata=%h err=%b ovr=%b, want all 0",
                                 i, mem_ready[i], mem_rdata[i], mem_error[i], overrun[i]);
                    end
                    sb[i].delete();
                    ovr_from[i] = INF;
                end else begin
                    n_tests++;
                    if (overrun[i] != (cyc >= ovr_from[i])) begin
                        n_fail++;
                        $display("FAIL overrun inst%0d cyc%0d: got %b want %b",
                                 i, cyc, overrun[i], (cyc >= ovr_from[i]));
                    end
                    if (mem_ready[i]) begin
                        n_tests++;
                        if (sb[i].size() == 0) begin
                            n_fail++;
                            $display("FAIL unexpected_ready inst%0d cyc%0d: ready=1 want 0", i, cyc);
                        end else begin
                            mon_e = sb[i].pop_front();
                            if (mon_e.due != cyc) begin
                                n_fail++;
                                $display("FAIL latency inst%0d: ready at cyc%0d want cyc%0d", i, cyc, mon_e.due);
                            end
                            n_tests++;
                            if (((mem_rdata[i] ^ mon_e.rdata) & mon_e.mask) != 32'h0) begin
                                n_fail++;
                                $display("FAIL rdata inst%0d cyc%0d: got %h want %h (mask %h)",
                                         i, cyc, mem_rdata[i], mon_e.rdata, mon_e.mask);
                            end
                            n_tests++;
                            if (mem_error[i] != mon_e.err) begin
                                n_fail++;
                                $display("FAIL error_flag inst%0d cyc%0d: got %b want %b",
                                         i, cyc, mem_error[i], mon_e.err);
                            end
                        end
                    end else begin
                        n_tests++;
                        if (mem_rdata[i] != 32'h0 || mem_error[i]) begin
                            n_fail++;
                            $display("FAIL idle_outputs inst%0d cyc%0d: rdata=%h err=%b want 0/0",
                                     i, cyc, mem_rdata[i], mem_error[i]);
                        end
                        if (sb[i].size() > 0 && sb[i][0].due <= cyc) begin
                            n_fail++;
                            $display("FAIL missing_ready inst%0d cyc%0d: ready=0 want 1", i, cyc);
                            void'(sb[i].pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [3:0]  s;
        int          r;
        for (int i = 0; i < NI; i++) begin
            mem_valid[i] = 1'b0;
            mem_addr[i]  = 32'h0;
            mem_wdata[i] = 32'h0;
            mem_wstrb[i] = 4'h0;
            next_free[i] = 0;
            ovr_from[i]  = INF;
            for (int w = 0; w < WORDS; w++) begin
                mdat[i][w]   = 32'h0;
                mknown[i][w] = 4'h0;
            end
        end
        do_reset(3, 1'b0);
        step();

        // one wait state: read in the write's response cycle sees the new data
        issue(0, 32'h10, 32'hDEAD_BEEF, 4'hF);
        step();
        issue(0, 32'h10, 32'h0, 4'h0);
        drain(0);

        issue(0, 32'h10, 32'h0000_00AA, 4'h1);
        step();
        issue(0, 32'h10, 32'h0000_BB00, 4'h2);
        step();
        issue(0, 32'h10, 32'h0, 4'h0);
        drain(0);

        // requests during reset must not write
        do_reset(3, 1'b1);
        step();
        issue(0, 32'h10, 32'h0, 4'h0);
        drain(0);

        // zero wait states: back-to-back
        issue(1, 32'h20, 32'h1234_5678, 4'hF);
        issue(1, 32'h20, 32'h0, 4'h0);
        issue(1, 32'h24, 32'hA5A5_5A5A, 4'hF);
        issue(1, 32'h24, 32'h0, 4'h0);
        drain(1);

        // window edges
        issue(0, 32'h0, 32'h0BAD_C0DE, 4'hF);
        step();
        issue(0, 32'h100, 32'h0, 4'h0);
        step();
        issue(0, 32'h100, 32'hFFFF_FFFF, 4'hF);
        step();
        issue(0, 32'h0, 32'h0, 4'h0);
        step();
        issue(0, 32'hFC, 32'h7777_8888, 4'hF);
        step();
        issue(0, 32'hFC, 32'h0, 4'h0);
        step();
        issue(2, 32'h0FFC, 32'h0, 4'h0);
        drain(0);
        drain(2);

        // overrun with three wait states, then reset clears it
        issue(2, 32'h1008, 32'h55AA_55AA, 4'hF);
        issue(2, 32'h1004, 32'h0000_0099, 4'hF);
        drain(2);
        issue(2, 32'h1008, 32'h0, 4'h0);
        drain(2);
        drive(2, 32'h1008, 32'hFFFF_FFFF, 4'hF);
        do_reset(2, 1'b0);
        step();
        issue(2, 32'h1008, 32'h0, 4'h0);
        drain(2);

        for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < 150; k++) begin
                repeat ($urandom_range(0, WC[i] + 1)) step();
                r = int'($urandom_range(0, 9));
                if (r == 0)      a = BASE[i] + 32'h100 + 32'($urandom_range(0, 3) * 4);
                else if (r == 1) a = $urandom();
                else if (r == 2) a = BASE[i] - 32'h4;
                else             a = BASE[i] + 32'($urandom_range(0, 15) * 4)
                                   + (($urandom_range(0, 1) == 1) ? 32'hC0 : 32'h0)
                                   + 32'($urandom_range(0, 3));
                s = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                issue(i, a, $urandom(), s);
            end
            drain(i);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
